// File: rtl/sirv_gnrl_rdfifo_if.sv
// Handshake bundle for sirv_gnrl_rdfifo: the producer side (i_*), the consumer side (o_*) and the occupancy count.
// DP and DW must match the parameters of the FIFO instance this bundle connects to.
interface sirv_gnrl_rdfifo_if #(
    parameter int DP = 4,
    parameter int DW = 32
);
    localparam int CW = $clog2(DP + 1);

    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [CW-1:0] cnt;

    modport master (
        output i_vld, i_dat, o_rdy,
        input  i_rdy, o_vld, o_dat, cnt
    );

    modport slave (
        input  i_vld, i_dat, o_rdy,
        output i_rdy, o_vld, o_dat, cnt
    );
endinterface

// File: rtl/sirv_gnrl_rdfifo.sv
// Parameterized valid/ready FIFO with binary wrap-at-DP pointers and a registered occupancy count.
// Define SIRV_GNRL_RDFIFO_BYPASS_EN to let an entry pass combinationally through an empty FIFO.
module sirv_gnrl_rdfifo #(
    parameter int DP = 4,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sirv_gnrl_rdfifo_if.slave bus
);
    localparam int            CW       = $clog2(DP + 1);
    localparam int            PW       = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DP);
    localparam logic [PW-1:0] PTR_LAST = PW'(DP - 1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DP];

    logic empty_s;
    logic full_s;
    logic byp_s;
    logic push_s;
    logic pop_s;

    // Handshake qualification; a bypassed entry is neither written nor popped from storage
    always_comb begin
        empty_s = (cnt_q == {CW{1'b0}});
        full_s  = (cnt_q == CNT_FULL);
`ifdef SIRV_GNRL_RDFIFO_BYPASS_EN
        byp_s   = empty_s & bus.i_vld & bus.o_rdy;
`else
        byp_s   = 1'b0;
`endif
        push_s  = bus.i_vld & ~full_s & ~byp_s;
        pop_s   = ~empty_s & bus.o_rdy;
    end

    // Next pointers and count
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_s) begin
            if (wptr_q == PTR_LAST) begin
                wptr_d = {PW{1'b0}};
            end else begin
                wptr_d = wptr_q + PW'(1'b1);
            end
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            if (rptr_q == PTR_LAST) begin
                rptr_d = {PW{1'b0}};
            end else begin
                rptr_d = rptr_q + PW'(1'b1);
            end
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage has no reset; stale entries are unreachable while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= bus.i_dat;
        end
    end

    // Outputs: i_rdy and cnt come straight from registered state, never from o_rdy
    always_comb begin
        bus.i_rdy = ~full_s;
        bus.cnt   = cnt_q;
`ifdef SIRV_GNRL_RDFIFO_BYPASS_EN
        if (empty_s) begin
            bus.o_vld = bus.i_vld;
            bus.o_dat = bus.i_dat;
        end else begin
            bus.o_vld = 1'b1;
            bus.o_dat = mem_q[rptr_q];
        end
`else
        bus.o_vld = ~empty_s;
        bus.o_dat = mem_q[rptr_q];
`endif
    end
endmodule

// File: doc/sirv_gnrl_rdfifo.md
# sirv_gnrl_rdfifo

Parameterized valid/ready FIFO that buffers data written by a producer and presents it to a consumer, one entry per handshake. It is the general-purpose decoupling buffer between pipeline stages in the core and the accelerator interfaces. Control state (pointers, count) uses the reset-to-0 load-enable flop style. Data storage uses the load-enable, no-reset flop style.

## Interface
- DP, default 4: FIFO depth in entries, must be ≥1; does not need to be a power of two.
- DW, default 32: data width in bits.
- CW, default $clog2(DP+1): occupancy count width; localparam, not overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_vld  input  1  producer presents valid data.
- i_rdy  output  1  FIFO can accept an entry.
- i_dat  input  DW  write data.
- o_vld  output  1  FIFO presents valid data.
- o_rdy  input  1  consumer accepts data.
- o_dat  output  DW  read data.
- cnt  output  CW  current occupancy, registered.

## Operation
- Push = i_vld & i_rdy. Pop = o_vld & o_rdy.
- Write pointer wptr and read pointer rptr are binary, range 0..DP-1.
  - Each pointer increments on its own handshake.
  - A pointer at DP-1 wraps to 0.
- cnt update rules:
  - push only: cnt+1.
  - pop only: cnt−1.
  - push and pop together: cnt unchanged, both pointers advance.
  - neither: hold.
- Derived flags: empty = (cnt==0), full = (cnt==DP).
- i_rdy = !full. It depends only on registered state; there is no combinational path from o_rdy.
  - A full FIFO with o_rdy=1 still deasserts i_rdy that cycle. Space frees the next cycle.
- o_vld = !empty; o_dat = mem[rptr].
  - When o_vld=0, o_dat is don't-care and must not be checked.
- On push, mem[wptr] is loaded with i_dat. Only the addressed entry is enabled.
- FIFO ordering is strict: output order equals input order, with no drops and no duplicates.
- Reset mid-operation:
  - All pointers and cnt return to 0.
  - Buffered entries are discarded.
  - Storage contents are not cleared and are never exposed while empty.
- DP=1 is legal and acts as a single-entry buffer with alternating full/empty.

## Timing
- Reset values: i_rdy=1, o_vld=0, cnt=0, wptr=rptr=0. o_dat is undefined.
- Latency without bypass: an entry pushed at edge N gives o_vld=1 in the cycle after edge N, with o_dat equal to that entry.
- Throughput: one push and one pop per cycle, sustained, while 0<cnt<DP.
- Full boundary: with cnt=DP, a pop at edge N gives i_rdy=1 after edge N.
- Empty boundary: with cnt=1 and a pop alone at edge N, o_vld=0 after edge N.
- cnt changes only at clock edges.

## Configuration
- Macro: SIRV_GNRL_RDFIFO_BYPASS_EN.
- Defined:
  - When empty, o_vld = i_vld and o_dat = i_dat, combinationally.
  - If empty & i_vld & o_rdy, the entry passes straight through. No write occurs, and pointers and cnt hold.
  - If empty & i_vld & !o_rdy, the entry is written normally.
  - Zero-cycle latency through an empty FIFO.
  - i_rdy is still !full.
- Undefined:
  - o_vld = !empty, as in Operation.
  - Minimum latency is 1 cycle.
  - No combinational input-to-output path.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately i_rdy=1, o_vld=0, cnt=0.
- Fill/drain, DP=4, o_rdy=0:
  - Push 0x11,0x22,0x33,0x44 -> cnt=4, i_rdy=0.
  - A 5th i_vld with 0x55 is not accepted.
  - Then o_rdy=1 -> outputs 0x11,0x22,0x33,0x44 in order, then o_vld=0, cnt=0.
- Streaming: i_vld=o_rdy=1 continuously with an incrementing pattern for 20 cycles, crossing pointer wrap -> cnt stays at 1 (non-bypass), output sequence matches input exactly.
- Full with simultaneous o_rdy=1 and i_vld=1 -> pop occurs, no push that cycle, cnt=3 next, i_rdy=1.
- Bypass:
  - With SIRV_GNRL_RDFIFO_BYPASS_EN, empty FIFO, i_vld=o_rdy=1, i_dat=0xA5 -> o_vld=1, o_dat=0xA5 the same cycle, cnt stays 0.
  - Without the macro: o_vld=0 that cycle, o_vld=1 with 0xA5 the next cycle.
- Reset mid-stream with cnt=3 -> cnt=0, o_vld=0. After release, push 0x77 -> first output is 0x77.
